// File: rtl/fp_result_checker.sv
// Scoreboard for FPU benches: expected results queue up in a FIFO and are
// compared in order against DUT results whenever dut_ready is asserted.
module fp_result_checker #(
  parameter int DATA_WIDTH   = 64,
  parameter int FLAG_WIDTH   = 5,
  parameter int DEPTH        = 8,
  parameter int CNT_WIDTH    = 32,
  parameter int NAN_RELAX    = 1,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [DATA_WIDTH-1:0]        push_result,
  input  logic [FLAG_WIDTH-1:0]        push_flags,
  input  logic [1:0]                   push_fmt,
  input  logic                         push_nan_ok,
  input  logic                         push_last,
  input  logic                         dut_ready,
  input  logic [DATA_WIDTH-1:0]        dut_result,
  input  logic [FLAG_WIDTH-1:0]        dut_flags,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [CNT_WIDTH-1:0]         pass_count,
  output logic [CNT_WIDTH-1:0]         fail_count,
  output logic                         fail,
  output logic [CNT_WIDTH-1:0]         fail_index,
  output logic [DATA_WIDTH-1:0]        fail_result_diff,
  output logic [FLAG_WIDTH-1:0]        fail_flags_diff,
  output logic                         overflow_err,
  output logic                         underflow_err,
  output logic                         done
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] result_mem [DEPTH];
  logic [FLAG_WIDTH-1:0] flags_mem  [DEPTH];
  logic [1:0]            fmt_mem    [DEPTH];
  logic                  nan_ok_mem [DEPTH];
  logic                  last_mem   [DEPTH];

  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, do_push, do_pop;

  logic [DATA_WIDTH-1:0] head_result;
  logic [FLAG_WIDTH-1:0] head_flags;
  logic [1:0]            head_fmt;
  logic                  head_nan_ok, head_last;

  logic [63:0]           dut64, ref64, diff64;
  logic [DATA_WIDTH-1:0] rdiff;
  logic [FLAG_WIDTH-1:0] fdiff;
  logic                  mismatch;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ready = !full && !done;
  assign do_push    = push_valid && push_ready;
  assign do_pop     = dut_ready && !empty && !done;
  assign occupancy  = OCC_W'(wr_ptr - rd_ptr);

  assign head_result = result_mem[rd_ptr[AW-1:0]];
  assign head_flags  = flags_mem[rd_ptr[AW-1:0]];
  assign head_fmt    = fmt_mem[rd_ptr[AW-1:0]];
  assign head_nan_ok = nan_ok_mem[rd_ptr[AW-1:0]];
  assign head_last   = last_mem[rd_ptr[AW-1:0]];

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (do_push) begin
      result_mem[wr_ptr[AW-1:0]] <= push_result;
      flags_mem[wr_ptr[AW-1:0]]  <= push_flags;
      fmt_mem[wr_ptr[AW-1:0]]    <= push_fmt;
      nan_ok_mem[wr_ptr[AW-1:0]] <= push_nan_ok;
      last_mem[wr_ptr[AW-1:0]]   <= push_last;
    end
  end

  // Work in 64 bits so the double-precision NaN test elaborates for either width.
  always_comb begin
    dut64  = 64'(dut_result);
    ref64  = 64'(head_result);
    diff64 = dut64 ^ ref64;
    if (NAN_RELAX != 0 && head_nan_ok) begin
      if (head_fmt == 2'd0 && dut64[31:0] == 32'h7FC0_0000) begin
        diff64        = '0;
        diff64[30:22] = dut64[30:22] ^ ref64[30:22];
      end else if (head_fmt != 2'd0 && dut64 == 64'h7FF8_0000_0000_0000) begin
        diff64        = '0;
        diff64[62:51] = dut64[62:51] ^ ref64[62:51];
      end
    end
  end

  assign rdiff    = diff64[DATA_WIDTH-1:0];
  assign fdiff    = dut_flags ^ head_flags;
  assign mismatch = (rdiff != '0) || (fdiff != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      pass_count       <= '0;
      fail_count       <= '0;
      fail             <= 1'b0;
      fail_index       <= '0;
      fail_result_diff <= '0;
      fail_flags_diff  <= '0;
      overflow_err     <= 1'b0;
      underflow_err    <= 1'b0;
      done             <= 1'b0;
    end else if (!done) begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (push_valid && full) overflow_err <= 1'b1;
      if (dut_ready && empty) underflow_err <= 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        if (mismatch) begin
          if (fail_count != '1) fail_count <= fail_count + CNT_WIDTH'(1);
          if (!fail) begin
            fail             <= 1'b1;
            fail_index       <= pass_count + fail_count;
            fail_result_diff <= rdiff;
            fail_flags_diff  <= fdiff;
          end
        end else if (pass_count != '1) begin
          pass_count <= pass_count + CNT_WIDTH'(1);
        end
        if (head_last || (mismatch && STOP_ON_FAIL != 0)) done <= 1'b1;
      end
    end
  end

endmodule
